// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//  Decode-to-fetch PC control bundle.
//  master : decode side, drives redirect/stall/halt requests, observes fetch.
//  slave  : pc_sequencer, consumes the requests, drives pc_f/fetch_valid/flush/trap.
interface pc_sequencer_if #(
  parameter int PC_W = 10
);
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     imm_add;
  logic            jalr_en;
  logic [31:0]     jalr_target;
  logic            halt;
  logic [PC_W-1:0] pc_f;
  logic            fetch_valid;
  logic            flush;
  logic            trap;

  modport master (
    output stall, branch_taken, pc_d, imm_add, jalr_en, jalr_target, halt,
    input  pc_f, fetch_valid, flush, trap
  );

  modport slave (
    input  stall, branch_taken, pc_d, imm_add, jalr_en, jalr_target, halt,
    output pc_f, fetch_valid, flush, trap
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//  Owns the fetch PC and picks the next one every cycle: sequential increment,
//  branch target (pc_d + imm_add), JALR target, stall hold or halt.
//  Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active-high
//   bus  - pc_sequencer_if.slave (requests in, pc_f/fetch_valid/flush/trap out)
//  Optional feature macro: PC_ALIGN_TRAP_EN
//   defined   : a misaligned redirect target enters TRAP (sticky trap, PC held)
//   undefined : target bits [1:0] are cleared, trap is tied 0
//
//  state  | meaning
//  RUN    | normal fetch, increment or hold on stall
//  REDIR  | one-cycle bubble after a redirect, flush asserted on entry
//  HALTED | fetch stopped, only rst leaves
//  TRAP   | misaligned redirect target, only rst leaves
module pc_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_sequencer_if.slave bus
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] REDIR  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [1:0] TRAP   = 2'd3;

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

  logic [1:0]      state;
  logic [PC_W-1:0] pc_q;
  logic            fetch_valid_q;
  logic            flush_q;
  logic            trap_q;

  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jalr_tgt;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] tgt_load;
  logic            redirect;

  // Only the low PC_W bits of the 32-bit sum matter, so the adder is PC_W wide.
  assign br_tgt   = bus.pc_d + bus.imm_add[PC_W-1:0];
  assign jalr_tgt = bus.jalr_target[PC_W-1:0] & ~PC_W'(1);
  assign tgt      = bus.jalr_en ? jalr_tgt : br_tgt;
  assign tgt_load = {tgt[PC_W-1:2], 2'b00};
  assign redirect = bus.jalr_en | bus.branch_taken;

  logic unused_hi;
  assign unused_hi = ^{bus.imm_add[31:PC_W], bus.jalr_target[31:PC_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b1;
      flush_q       <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      case (state)
        RUN, REDIR: begin
          if (bus.halt) begin
            state         <= HALTED;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
          end else if (redirect) begin
`ifdef PC_ALIGN_TRAP_EN
            if (tgt[1:0] != 2'b00) begin
              state         <= TRAP;
              trap_q        <= 1'b1;
              fetch_valid_q <= 1'b0;
              flush_q       <= 1'b1;
            end else begin
              pc_q          <= tgt_load;
              state         <= REDIR;
              fetch_valid_q <= 1'b0;
              flush_q       <= 1'b1;
            end
`else
            pc_q          <= tgt_load;
            state         <= REDIR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b1;
`endif
          end else if (bus.stall) begin
            // Stall keeps the state; a stalled bubble stays invalid.
            fetch_valid_q <= (state == RUN);
            flush_q       <= 1'b0;
          end else begin
            pc_q          <= pc_q + INC;
            state         <= RUN;
            fetch_valid_q <= 1'b1;
            flush_q       <= 1'b0;
          end
        end
        HALTED, TRAP: begin
          fetch_valid_q <= 1'b0;
          flush_q       <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.pc_f        = pc_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.flush       = flush_q;
`ifdef PC_ALIGN_TRAP_EN
  assign bus.trap        = trap_q;
`else
  assign bus.trap        = 1'b0;
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule
